// File: rtl/mdu_sequencer_if.sv
// Command/result bundle between the execute stage and the multiply/divide sequencer.
// The cancel signal exists only when MDU_CANCEL_EN is defined.
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hilo_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  modport master (
    output start, mdu_op, rs_data, rt_data, hilo_use,
`ifdef MDU_CANCEL_EN
    output cancel,
`endif
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data, hilo_use,
`ifdef MDU_CANCEL_EN
    input  cancel,
`endif
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Fixed-latency multiply/divide controller owning HI/LO; results land when the busy window ends.
// Optional macro MDU_CANCEL_EN adds a cancel input that abandons an in-flight operation.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  mdu_sequencer_if.slave   bus
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      r_state;
  logic [3:0]  r_count;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;

  logic        w_cancel;
  logic        w_is_muldiv;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_sdiv_b;
  logic [31:0] w_udiv_b;
  logic signed [63:0] w_sa64;
  logic signed [63:0] w_sb64;
  logic signed [63:0] w_smul;
  logic [63:0] w_umul;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_wr;
  logic [3:0]  w_load_count;

`ifdef MDU_CANCEL_EN
  assign w_cancel = bus.cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_is_muldiv = bus.start && (bus.mdu_op >= OpMult) && (bus.mdu_op <= OpDivu);

  assign w_sa64 = {{32{bus.rs_data[31]}}, bus.rs_data};
  assign w_sb64 = {{32{bus.rt_data[31]}}, bus.rt_data};
  assign w_smul = w_sa64 * w_sb64;
  assign w_umul = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};

  // Substitute a divisor of 1 for the zero and min/-1 cases: keeps the divider defined and
  // yields exactly quotient 0x80000000, remainder 0 for the overflow case.
  assign w_div_zero = (bus.rt_data == 32'd0);
  assign w_div_ovf  = (bus.rs_data == 32'h8000_0000) && (bus.rt_data == 32'hFFFF_FFFF);
  assign w_sdiv_b   = (w_div_zero || w_div_ovf) ? 32'd1 : bus.rt_data;
  assign w_udiv_b   = w_div_zero ? 32'd1 : bus.rt_data;

  assign w_sq = $signed(bus.rs_data) / $signed(w_sdiv_b);
  assign w_sr = $signed(bus.rs_data) % $signed(w_sdiv_b);
  assign w_uq = bus.rs_data / w_udiv_b;
  assign w_ur = bus.rs_data % w_udiv_b;

  always_comb begin
    w_res_hi     = 32'd0;
    w_res_lo     = 32'd0;
    w_res_wr     = 1'b0;
    w_load_count = 4'(DIV_CYCLES);
    case (bus.mdu_op)
      OpMult: begin
        w_res_hi     = w_smul[63:32];
        w_res_lo     = w_smul[31:0];
        w_res_wr     = 1'b1;
        w_load_count = 4'(MULT_CYCLES);
      end
      OpMultu: begin
        w_res_hi     = w_umul[63:32];
        w_res_lo     = w_umul[31:0];
        w_res_wr     = 1'b1;
        w_load_count = 4'(MULT_CYCLES);
      end
      OpDiv: begin
        w_res_hi = w_sr;
        w_res_lo = w_sq;
        w_res_wr = !w_div_zero;
      end
      OpDivu: begin
        w_res_hi = w_ur;
        w_res_lo = w_uq;
        w_res_wr = !w_div_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_count   <= 4'd0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_is_muldiv) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
            r_count   <= w_load_count;
            r_busy    <= 1'b1;
            r_state   <= StBusy;
          end else if (bus.start && bus.mdu_op == OpMthi) begin
            r_hi <= bus.rs_data;
          end else if (bus.start && bus.mdu_op == OpMtlo) begin
            r_lo <= bus.rs_data;
          end
        end
        StBusy: begin
          // New commands are ignored here; upstream is expected to be stalled.
          if (w_cancel) begin
            r_count   <= 4'd0;
            r_busy    <= 1'b0;
            r_pend_wr <= 1'b0;
            r_state   <= StIdle;
          end else if (r_count == 4'd1) begin
            r_count   <= 4'd0;
            r_busy    <= 1'b0;
            r_pend_wr <= 1'b0;
            r_state   <= StIdle;
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.stall_req = bus.hilo_use && (r_busy || w_is_muldiv);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed scoreboard bench for mdu_sequencer; cancel steps run when MDU_CANCEL_EN is defined.
module tb_mdu_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] sb_q[$];

  mdu_sequencer_if bus ();

  mdu_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mdu_op  = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
  endtask

  // Counts busy cycles from the cycle after the start edge; bounded so it cannot hang.
  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int n, input int ncyc);
    logic [63:0] e;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(ncyc));
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, bus.hi, e[63:32]);
      chk({tag, "_lo"}, bus.lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ncyc);
    int n;
    sb_q.push_back({eh, el});
    issue(op, a, b);
    wait_busy(n);
    check_result(tag, n, ncyc);
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.mdu_op   = 3'd0;
    bus.rs_data  = 32'd0;
    bus.rt_data  = 32'd0;
    bus.hilo_use = 1'b0;
`ifdef MDU_CANCEL_EN
    bus.cancel   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_stall", {31'd0, bus.stall_req}, 32'd0);
    reset_n = 1'b1;

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("divu_small", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op("div_negdivisor", 3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);

    issue(3'd6, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", bus.lo, 32'hCAFE_F00D);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    m_lo = 32'hCAFE_F00D;
    issue(3'd5, 32'h1234_5678, 32'd0);
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    m_hi = 32'h1234_5678;

    issue(3'd7, 32'h5555_5555, 32'd3);
    chk("op7_busy", {31'd0, bus.busy}, 32'd0);
    chk("op7_hi", bus.hi, m_hi);
    chk("op7_lo", bus.lo, m_lo);

    run_op("divu_zero", 3'd4, 32'd9, 32'd0, m_hi, m_lo, 10);

    // stall_req is combinational on a same-cycle mul/div start
    sb_q.push_back({32'd1, 32'd0});
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mdu_op   = 3'd2;
    bus.rs_data  = 32'h0001_0000;
    bus.rt_data  = 32'h0001_0000;
    bus.hilo_use = 1'b1;
    #1 chk("stall_on_start", {31'd0, bus.stall_req}, 32'd1);
    bus.hilo_use = 1'b0;
    #1 chk("stall_no_use", {31'd0, bus.stall_req}, 32'd0);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
    wait_busy(n);
    check_result("multu_2to32", n, 5);

    // DIV in flight with a MULT pulsed at busy cycle 3
    bus.hilo_use = 1'b1;
    sb_q.push_back({32'd2, 32'hFFFF_FFF2});
    issue(3'd3, 32'd100, 32'hFFFF_FFF9);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      chk("stall_in_busy", {31'd0, bus.stall_req}, 32'd1);
      if (n == 3) begin
        $display("note: start issued while busy (protocol error, must be ignored)");
        bus.start   = 1'b1;
        bus.mdu_op  = 3'd1;
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd5;
      end else begin
        bus.start  = 1'b0;
        bus.mdu_op = 3'd0;
      end
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
    check_result("div_with_ignored", n, 10);
    chk("stall_idle", {31'd0, bus.stall_req}, 32'd0);
    @(negedge clk);
    chk("ignored_busy", {31'd0, bus.busy}, 32'd0);
    chk("ignored_hi", bus.hi, m_hi);
    chk("ignored_lo", bus.lo, m_lo);
    bus.hilo_use = 1'b0;

    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

    // asynchronous reset in the middle of a MULT
    issue(3'd1, 32'd3, 32'd4);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_reset_hi", bus.hi, 32'd0);
    chk("async_reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_op("multu_after_reset", 3'd2, 32'd3, 32'd5, 32'd0, 32'd15, 5);

`ifdef MDU_CANCEL_EN
    issue(3'd1, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_hi", bus.hi, m_hi);
    chk("cancel_lo", bus.lo, m_lo);
    repeat (6) @(negedge clk);
    chk("cancel_late_lo", bus.lo, m_lo);

    issue(3'd1, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_final_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_final_hi", bus.hi, m_hi);
    chk("cancel_final_lo", bus.lo, m_lo);

    sb_q.push_back({32'd0, 32'd6});
    @(negedge clk);
    bus.cancel  = 1'b1;
    bus.start   = 1'b1;
    bus.mdu_op  = 3'd1;
    bus.rs_data = 32'd2;
    bus.rt_data = 32'd3;
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    bus.mdu_op = 3'd0;
    wait_busy(n);
    check_result("cancel_idle_start", n, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller with HI/LO registers, sitting beside the single-cycle ALU in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and holds a busy window of fixed latency.
- Produces a stall request so the pipeline cannot read or overwrite HI/LO while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  command valid this cycle
- mdu_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- rs_data  input  32  operand A, or the MTHI/MTLO source
- rt_data  input  32  operand B
- hilo_use  input  1  the instruction in execute reads or writes HI/LO
- busy  output  1  operation in flight
- stall_req  output  1  combinational: hilo_use & (busy | (start & mdu_op in 1..4))
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (asynchronous assert, synchronous-release use): state=IDLE, count=0, busy=0, hi=0, lo=0, pending result cleared. Reset during BUSY abandons the operation; HI/LO read 0.
- States: IDLE, BUSY.
- IDLE with start and mdu_op 1..4, sampled at edge T:
  - Compute the result from operands latched at T into pending_hi/pending_lo.
  - Load count with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - busy=1 during cycles T+1 .. T+N.
- BUSY: count decrements each edge. At the edge where count goes 1 -> 0, hi/lo take pending values and state returns to IDLE. New HI/LO are visible in the same cycle busy drops.
- MTHI/MTLO in IDLE with start: hi (or lo) <= rs_data at that edge, with no busy cycle.
- start while BUSY, any op: ignored with no state change. Upstream must have stalled; the bench flags it as a protocol error.
- mdu_op 0 or 7 with start: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divisor 0 (DIV or DIVU): busy is still held for DIV_CYCLES; hi/lo unchanged at completion.
- Outputs hi, lo and busy are registered. stall_req is the only combinational output.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel=1 at an edge while BUSY: state goes to IDLE, busy=0 from the next cycle, hi/lo retain their pre-operation values, and the pending result is discarded.
  - cancel coincident with the final count edge: cancel wins and hi/lo are unchanged.
  - cancel in IDLE: no effect. It also does not block a same-cycle start.
- Not defined: cancel port absent; every started operation runs to completion.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD, rt=7 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. Then DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI rs=0x12345678 -> hi=0x12345678 next cycle with busy=0. Then DIVU rt=0 -> busy 10 cycles; hi=0x12345678 and lo unchanged afterwards.
- DIV started, then MULT pulsed at busy cycle 3 with hilo_use=1 -> stall_req=1 through the busy window; the MULT is ignored and only the DIV result lands. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Deassert reset_n at busy cycle 2 of a MULT -> busy, hi, lo read 0 immediately (asynchronous). After release, a new MULTU completes normally.
- With MDU_CANCEL_EN: MULT in flight, cancel at busy cycle 4 -> busy=0 next cycle; hi/lo equal their pre-start values.
